// File: rtl/fetch_stage.sv
// Instruction fetch with writable instruction memory and IF/ID register.
// Handles stall, EX redirect and HALT; feeds control_unit.
module fetch_stage #(
  parameter int PC_W       = 8,
  parameter int IMEM_DEPTH = 256,
  parameter int INSTR_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus1_out,
  output logic               valid_out,
  output logic               halted
);

  localparam logic [INSTR_W-1:0] NOP = '0;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  typedef enum logic {
    RUN,
    HALT_ST
  } state_t;

  logic [INSTR_W-1:0] mem [IMEM_DEPTH];
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_inc;
  state_t             state;
  logic               rd_ok;
  logic               wr_ok;
  logic [INSTR_W-1:0] word;
  logic               is_halt;

  // Addresses beyond the implemented depth read as NOP, writes are dropped
  generate
    if (IMEM_DEPTH >= 2 ** PC_W) begin : g_full
      assign rd_ok = 1'b1;
      assign wr_ok = 1'b1;
    end else begin : g_part
      assign rd_ok = int'(pc) < IMEM_DEPTH;
      assign wr_ok = int'(imem_waddr) < IMEM_DEPTH;
    end
  endgenerate

  assign word    = rd_ok ? mem[pc[AW-1:0]] : NOP;
  assign is_halt = word[INSTR_W-1 -: 4] == OP_HALT;
  assign pc_inc  = pc + PC_W'(1);

  always_ff @(posedge clk) begin
    if (imem_we && wr_ok)
      mem[imem_waddr[AW-1:0]] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc           <= '0;
      instr_out    <= NOP;
      pc_out       <= '0;
      pc_plus1_out <= '0;
      valid_out    <= 1'b0;
      halted       <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            pc        <= redirect_pc;
            instr_out <= NOP;
            valid_out <= 1'b0;
          end else if (!stall) begin
            instr_out    <= word;
            pc_out       <= pc;
            pc_plus1_out <= pc_inc;
            valid_out    <= 1'b1;
            if (is_halt) begin
              state  <= HALT_ST;
              halted <= 1'b1;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        HALT_ST: begin
          if (redirect) begin
            pc        <= redirect_pc;
            instr_out <= NOP;
            valid_out <= 1'b0;
            state     <= RUN;
            halted    <= 1'b0;
          end else if (!stall) begin
            instr_out <= NOP;
            valid_out <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
